// File: rtl/io_uart_tx_if.sv
// CPU I/O bus as seen by a memory-mapped peripheral: address, write data,
// write strobe, and combinational read data back to the core.
interface io_uart_tx_if;
    logic [7:0] io_bus_addr;
    logic [7:0] io_bus_dout;
    logic       io_bus_we;
    logic [7:0] io_bus_din;

    modport master (
        output io_bus_addr,
        output io_bus_dout,
        output io_bus_we,
        input  io_bus_din
    );

    modport slave (
        input  io_bus_addr,
        input  io_bus_dout,
        input  io_bus_we,
        output io_bus_din
    );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes feed a small FIFO that a
// start/data/stop FSM drains onto a registered tx line.
module io_uart_tx #(
    parameter logic [7:0] DATA_ADDR    = 8'hF0,
    parameter logic [7:0] STATUS_ADDR  = 8'hF1,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    io_uart_tx_if.slave bus,
    output logic        tx,
    output logic        fifo_full,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic       fifo_empty, push_req, push_ok, pop, clr_ovf;
    logic [7:0] status;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign busy       = (state_q != S_IDLE);
    assign tx         = tx_q;

    assign push_req = bus.io_bus_we && (bus.io_bus_addr == DATA_ADDR);
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign push_ok  = push_req && (!fifo_full || pop);
    assign clr_ovf  = bus.io_bus_we && (bus.io_bus_addr == STATUS_ADDR);

    assign status         = {4'b0000, overflow_q, busy, fifo_empty, fifo_full};
    assign bus.io_bus_din = (bus.io_bus_addr == STATUS_ADDR) ? status : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.io_bus_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) overflow_q <= 1'b1;
            else if (clr_ovf)         overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_io_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic tx, fifo_full, busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    io_uart_tx_if bus();

    io_uart_tx #(
        .DATA_ADDR(8'hF0), .STATUS_ADDR(8'hF1),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tx(tx), .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.io_bus_addr = a;
        bus.io_bus_dout = d;
        bus.io_bus_we   = 1'b1;
        @(negedge clk);
        bus.io_bus_we   = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] s);
        bus.io_bus_addr = 8'hF1;
        bus.io_bus_we   = 1'b0;
        #1;
        s = bus.io_bus_din;
    endtask

    // Receiver: waits for a start bit, samples mid-bit, returns at the last stop-bit cycle.
    task automatic rx_byte(output logic [7:0] d, output bit ok);
        int t = 0;
        ok = 1'b1;
        d  = 8'h00;
        while (tx !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            if (k >= 6 && k <= 34 && (k % 4) == 2) d[(k - 6) / 4] = tx;
            if (k == 38 && tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst = 1'b1;
        bus.io_bus_addr = 8'h00;
        bus.io_bus_dout = 8'h00;
        bus.io_bus_we   = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        read_status(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL reset_status: got %h want 02", s); end
        bus.io_bus_addr = 8'hF0;
        #1;
        n_cmp++; if (bus.io_bus_din !== 8'h00) begin n_bad++; $display("FAIL din_other_addr: got %h want 00", bus.io_bus_din); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: tx=%b busy=%b want 1/0", tx, busy); end
    endtask

    // Checks 40 consecutive cycles of tx starting at the sample where tx has just fallen.
    task automatic check_frame(input logic [7:0] d, input logic end_busy, input string nm);
        logic [9:0] fr;
        logic       exp_b;
        fr = {1'b1, d, 1'b0};
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (tx !== fr[k / 4]) begin
                n_bad++;
                $display("FAIL %s_tx[%0d]: got %b want %b", nm, k, tx, fr[k / 4]);
            end
            exp_b = (k == 39) ? end_busy : 1'b1;
            n_cmp++;
            if (busy !== exp_b) begin
                n_bad++;
                $display("FAIL %s_busy[%0d]: got %b want %b", nm, k, busy, exp_b);
            end
        end
    endtask

    task automatic test_single_byte();
        bus_write(8'hF0, 8'hA5);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_lat_e0: tx=%b want 1", tx); end
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_lat_e1: tx=%b busy=%b want 1/1", tx, busy); end
        @(negedge clk);
        check_frame(8'hA5, 1'b0, "single");
    endtask

    task automatic test_back_to_back();
        bus_write(8'hF0, 8'h01);
        bus_write(8'hF0, 8'h80);
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_lat: tx=%b busy=%b want 1/1", tx, busy); end
        @(negedge clk);
        check_frame(8'h01, 1'b1, "b2b_first");
        @(negedge clk);
        check_frame(8'h80, 1'b0, "b2b_second");
    endtask

    task automatic test_overflow();
        logic [7:0] got [10];
        bit         oks [10];
        logic [7:0] s;
        fork
            begin
                for (int i = 0; i < 9; i++) bus_write(8'hF0, 8'h10 + 8'(i));
                read_status(s);
                n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full_after9: got %b want 1", fifo_full); end
                n_cmp++; if (s !== 8'h05) begin n_bad++; $display("FAIL ovf_status_after9: got %h want 05", s); end
                repeat (32) @(negedge clk);
                bus_write(8'hF0, 8'h19);
                read_status(s);
                n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL pushpop_full: got %b want 1", fifo_full); end
                n_cmp++; if (s !== 8'h05) begin n_bad++; $display("FAIL pushpop_status: got %h want 05", s); end
                bus_write(8'hF0, 8'h1A);
                read_status(s);
                n_cmp++; if (s !== 8'h0D) begin n_bad++; $display("FAIL ovf_status_drop: got %h want 0D", s); end
                read_status(s);
                n_cmp++; if (s !== 8'h0D) begin n_bad++; $display("FAIL ovf_sticky_on_read: got %h want 0D", s); end
                bus_write(8'hF1, 8'h00);
                read_status(s);
                n_cmp++; if (s !== 8'h05) begin n_bad++; $display("FAIL ovf_clear: got %h want 05", s); end
            end
            begin
                for (int i = 0; i < 10; i++) rx_byte(got[i], oks[i]);
            end
        join
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (!oks[i] || got[i] !== 8'h10 + 8'(i)) begin
                n_bad++;
                $display("FAIL ovf_order[%0d]: got %h ok=%0d want %h", i, got[i], oks[i], 8'h10 + 8'(i));
            end
        end
        begin
            int lows = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL ovf_dropped_not_sent: low cycles %0d want 0", lows); end
        end
        read_status(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL ovf_final_status: got %h want 02", s); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] s;
        int         bad = 0;
        @(negedge clk);
        bus_write(8'hF0, 8'h55);
        bus_write(8'hF0, 8'h66);
        bus_write(8'hF0, 8'h77);
        bus_write(8'hF0, 8'h88);
        repeat (15) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_bit3: tx=%b want 0", tx); end
        read_status(s);
        n_cmp++; if (s !== 8'h04) begin n_bad++; $display("FAIL mid_status_before: got %h want 04", s); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0 || fifo_full !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: busy=%b full=%b want 0/0", busy, fifo_full); end
        read_status(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL mid_rst_status: got %h want 02", s); end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid_no_more_frames: bad cycles %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
